// File: rtl/mem_bilo_db_rd.sv
// mem_bilo_db_rd: read-side sequencer for the deblocking line buffer.
// Sweeps an 8-bit line address range, captures returned lines into a small
// FIFO and hands them downstream over valid/ready without drop or duplicate.
// Optional feature macro: MEM_BILO_DB_RD_LAST_EN (adds last_o and per-entry tag).
module mem_bilo_db_rd #(
  parameter int unsigned RD_DEPTH    = 2,
  parameter int unsigned PIXEL_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  input  logic [1:0]                sel_i,
  output logic                      ren_o,
  output logic [7:0]                raddr_o,
  input  logic [PIXEL_WIDTH*32-1:0] rdata_i,
  output logic                      val_o,
  output logic [PIXEL_WIDTH*32-1:0] data_o,
  input  logic                      ready_i,
  output logic                      busy_o,
`ifdef MEM_BILO_DB_RD_LAST_EN
  output logic                      done_o,
  output logic                      last_o
`else
  output logic                      done_o
`endif
);

  localparam int unsigned LINE_W = PIXEL_WIDTH * 32;
  localparam int unsigned PTR_W  = (RD_DEPTH > 2) ? 2 : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned OCC_W  = CNT_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         addr_q;
  logic [7:0]         end_q;
  logic [7:0]         lo_addr, hi_addr;
  logic               inflight_q;
  logic               busy_q, done_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LINE_W-1:0]  mem_q [RD_DEPTH];
  logic               fifo_val;
  logic               push, pop;
  logic               credit_ok;
  logic               issue;
  logic               issue_last;

`ifdef MEM_BILO_DB_RD_LAST_EN
  logic [RD_DEPTH-1:0] tag_q;
  logic                inflight_last_q;
`endif

  // Region decode: first and last line address of the selected sweep.
  always_comb begin
    lo_addr = 8'd0;
    hi_addr = 8'd207;
    case (sel_i)
      2'd0:    begin lo_addr = 8'd0;   hi_addr = 8'd127; end
      2'd1:    begin lo_addr = 8'd128; hi_addr = 8'd191; end
      2'd2:    begin lo_addr = 8'd192; hi_addr = 8'd207; end
      default: begin lo_addr = 8'd0;   hi_addr = 8'd207; end
    endcase
  end

  // Issue/credit and next-state logic. A pop this cycle frees a slot, so the
  // read for the next line can go out immediately and sustain one line/cycle.
  always_comb begin
    fifo_val   = (cnt_q != '0);
    pop        = fifo_val && ready_i;
    push       = inflight_q;
    credit_ok  = (OCC_W'(cnt_q) + OCC_W'(inflight_q)) < (OCC_W'(RD_DEPTH) + OCC_W'(pop));
    issue      = (state_q == S_READ) && credit_ok;
    issue_last = issue && (addr_q == end_q);
    cnt_d      = CNT_W'(cnt_q + CNT_W'(push) - CNT_W'(pop));
    state_d    = state_q;
    case (state_q)
      S_IDLE:  if (start_i)     state_d = S_READ;
      S_READ:  if (issue_last)  state_d = S_DRAIN;
      S_DRAIN: if (cnt_d == '0) state_d = S_DONE;
      S_DONE:                   state_d = S_IDLE;
      default:                  state_d = S_IDLE;
    endcase
  end

  // Sequencer state, address counter, in-flight tracking and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= 8'd0;
      end_q      <= 8'd0;
      inflight_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      busy_q     <= (state_d != S_IDLE);
      done_q     <= (state_d == S_DONE);
      if ((state_q == S_IDLE) && start_i) begin
        addr_q <= lo_addr;
        end_q  <= hi_addr;
      end else if (issue) begin
        addr_q <= addr_q + 8'd1;
      end
    end
  end

  // Line FIFO: captures the line returned one cycle after each read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(RD_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      if (push) begin
        mem_q[wr_ptr_q] <= rdata_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

`ifdef MEM_BILO_DB_RD_LAST_EN
  // End-of-sweep tag follows its line through the pipeline and FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_last_q <= 1'b0;
      tag_q           <= '0;
    end else begin
      inflight_last_q <= issue_last;
      if (push) begin
        tag_q[wr_ptr_q] <= inflight_last_q;
      end
    end
  end

  assign last_o = fifo_val && tag_q[rd_ptr_q];
`else
  logic unused_last;
  assign unused_last = issue_last;
`endif

  assign ren_o   = issue;
  assign raddr_o = addr_q;
  assign val_o   = fifo_val;
  assign data_o  = mem_q[rd_ptr_q];
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_mem_bilo_db_rd.sv
// Self-checking bench for mem_bilo_db_rd: random RAM contents and ready
// patterns, checked against a per-sweep queue of expected line addresses.
module tb_mem_bilo_db_rd;

  localparam int unsigned RD_DEPTH    = 2;
  localparam int unsigned PIXEL_WIDTH = 8;
  localparam int unsigned LINE_W      = PIXEL_WIDTH * 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start_i;
  logic [1:0]        sel_i;
  logic              ren_o;
  logic [7:0]        raddr_o;
  logic [LINE_W-1:0] rdata_i;
  logic              val_o;
  logic [LINE_W-1:0] data_o;
  logic              ready_i;
  logic              busy_o;
  logic              done_o;
`ifdef MEM_BILO_DB_RD_LAST_EN
  logic              last_o;
`endif

  mem_bilo_db_rd #(.RD_DEPTH(RD_DEPTH), .PIXEL_WIDTH(PIXEL_WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_i),
    .sel_i   (sel_i),
    .ren_o   (ren_o),
    .raddr_o (raddr_o),
    .rdata_i (rdata_i),
    .val_o   (val_o),
    .data_o  (data_o),
    .ready_i (ready_i),
    .busy_o  (busy_o),
`ifdef MEM_BILO_DB_RD_LAST_EN
    .done_o  (done_o),
    .last_o  (last_o)
`else
    .done_o  (done_o)
`endif
  );

  always #5 clk = ~clk;

  logic [LINE_W-1:0] ram [208];

  // Line buffer model: synchronous read, garbage when not enabled.
  always @(posedge clk) begin
    if (ren_o && (raddr_o < 8'd208)) rdata_i <= ram[raddr_o];
    else                             rdata_i <= {8{$urandom}};
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [LINE_W-1:0] got,
                       input logic [LINE_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference-model bookkeeping for the current sweep.
  int exp_q[$];
  int next_rd, rd_end;
  int reads, beats, dones, max_out;
  int cyc, done_cyc, first_ren_cyc, first_val_cyc;

  // One clock cycle: drive inputs mid-cycle, then observe and score outputs.
  task automatic step(input bit rdy, input bit st, input logic [1:0] sl);
    int a;
    @(negedge clk);
    ready_i = rdy;
    start_i = st;
    sel_i   = sl;
    #1;
    cyc++;
    if (ren_o) begin
      if (first_ren_cyc < 0) first_ren_cyc = cyc;
      check("raddr", LINE_W'(raddr_o), LINE_W'(next_rd));
      next_rd++;
      reads++;
    end
    if (val_o && first_val_cyc < 0) first_val_cyc = cyc;
    if (val_o && ready_i) begin
      if (exp_q.size() == 0) begin
        check("extra_beat", 1, 0);
      end else begin
        a = exp_q.pop_front();
        check("beat_data", data_o, ram[a]);
`ifdef MEM_BILO_DB_RD_LAST_EN
        check("last_o", LINE_W'(last_o), LINE_W'(a == rd_end));
`endif
      end
      beats++;
    end
    if (done_o) begin
      dones++;
      done_cyc = cyc;
    end
    if (reads - beats > max_out) max_out = reads - beats;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_ren"},   LINE_W'(ren_o),   0);
    check({pfx, "_raddr"}, LINE_W'(raddr_o), 0);
    check({pfx, "_val"},   LINE_W'(val_o),   0);
    check({pfx, "_data"},  data_o,           0);
    check({pfx, "_busy"},  LINE_W'(busy_o),  0);
    check({pfx, "_done"},  LINE_W'(done_o),  0);
`ifdef MEM_BILO_DB_RD_LAST_EN
    check({pfx, "_last"},  LINE_W'(last_o),  0);
`endif
  endtask

  task automatic begin_sweep(input logic [1:0] sl);
    int lo, hi;
    case (sl)
      2'd0:    begin lo = 0;   hi = 127; end
      2'd1:    begin lo = 128; hi = 191; end
      2'd2:    begin lo = 192; hi = 207; end
      default: begin lo = 0;   hi = 207; end
    endcase
    exp_q.delete();
    for (int a = lo; a <= hi; a++) exp_q.push_back(a);
    next_rd = lo; rd_end = hi;
    reads = 0; beats = 0; dones = 0; max_out = 0;
    done_cyc = -1; first_ren_cyc = -1; first_val_cyc = -1;
  endtask

  // mode: 0 ready high, 1 toggling, 2 stall 20 cycles then random, 3 random.
  task automatic run_sweep(input logic [1:0] sl, input int mode,
                           input int mid_start_at, input bit start_in_done);
    int n, cs;
    bit rdy, st;
    begin_sweep(sl);
    n = exp_q.size();
    step(1'b1, 1'b1, sl);
    cs = cyc;
    for (int k = 1; k < 4000 && dones == 0; k++) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = k[0];
        2:       rdy = (k <= 20) ? 1'b0 : 1'($urandom_range(0, 1));
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      st = (k == mid_start_at) || (start_in_done && k == n + 3);
      step(rdy, st, 2'd1);
      if (mode == 2 && k == 20) begin
        check("stall_reads", LINE_W'(reads), LINE_W'(RD_DEPTH));
        check("stall_ren", LINE_W'(ren_o), 0);
      end
    end
    if (dones == 0) check("done_timeout", 0, 1);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 2'd0);
    check("first_ren", LINE_W'(first_ren_cyc), LINE_W'(cs + 1));
    check("beats", LINE_W'(beats), LINE_W'(n));
    check("reads", LINE_W'(reads), LINE_W'(n));
    check("dones", LINE_W'(dones), 1);
    check("model_left", LINE_W'(exp_q.size()), 0);
    check("max_outstanding", LINE_W'(max_out <= int'(RD_DEPTH)), 1);
    check("busy_after", LINE_W'(busy_o), 0);
    if (mode == 0) begin
      check("first_val", LINE_W'(first_val_cyc), LINE_W'(cs + 3));
      check("done_cycle", LINE_W'(done_cyc), LINE_W'(cs + n + 3));
    end
  endtask

  initial begin
    rst_n = 1'b0; start_i = 1'b0; sel_i = 2'd0; ready_i = 1'b0; cyc = 0;
    for (int a = 0; a < 208; a++) ram[a] = {8{32'h0}} | {$urandom, $urandom, $urandom,
      $urandom, $urandom, $urandom, $urandom, $urandom};
    begin_sweep(2'd0);
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 2'd0);

    run_sweep(2'd2, 0, -1, 1'b0);
    run_sweep(2'd0, 1, -1, 1'b0);
    run_sweep(2'd3, 2, -1, 1'b0);
    run_sweep(2'd0, 0, 30, 1'b1);

    // Abort a sweep with reset, then a clean chroma sweep.
    begin_sweep(2'd0);
    step(1'b1, 1'b1, 2'd0);
    for (int k = 0; k < 40; k++) step(1'($urandom_range(0, 1)), 1'b0, 2'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    begin_sweep(2'd1);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 2'd0);
    check("abort_no_done", LINE_W'(dones), 0);
    run_sweep(2'd1, 3, -1, 1'b0);

    for (int s = 0; s < 4; s++) run_sweep(2'(s), 3, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
